bp_be_trace_arbiter: RTL and testbench
======================================

Name: bp_be_trace_arbiter

Overview:
- Collects per-core commit trace records from num_core_p backends and serializes them onto one shared trace/host channel.
- Uses per-core buffering and round-robin arbitration.
- Tracks per-core test completion (pass/fail finish records) and raises all_done_o once every core has finished and all buffered records have drained.
- Sits between the BE commit stages and the single testbench trace sink / host I/O port.

Parameters:
- num_core_p, 4, number of requesting cores (1..16).
- rec_width_p, 128, width of one opaque commit record.
- fifo_els_p, 4, per-core buffer depth; power of 2, >= 2.
- core_id_width_lp, clog2(num_core_p) (min 1), width of core index (localparam).

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous active-high reset.
- rec_v_i  in  num_core_p  per-core record valid. Commit cannot stall, so there is no ready.
- rec_data_i  in  num_core_p*rec_width_p  records; core i occupies [i*rec_width_p +: rec_width_p].
- rec_finish_i  in  num_core_p  record is a test-finish record (qualified by rec_v_i).
- rec_pass_i  in  num_core_p  finish outcome: 1 = pass, 0 = fail (qualified by rec_finish_i).
- trace_v_o  out  1  output record valid.
- trace_ready_i  in  1  sink accepts the record.
- trace_data_o  out  rec_width_p  granted record.
- trace_core_o  out  core_id_width_lp  source core of trace_data_o.
- trace_finish_o  out  1  granted record is a finish record.
- trace_stamp_o  out  32  enqueue timestamp (see Optional Feature).
- core_done_o  out  num_core_p  sticky: core's finish record has been delivered.
- core_pass_o  out  num_core_p  sticky pass flag, meaningful only where core_done_o is set.
- overflow_o  out  num_core_p  sticky: a record from that core was dropped.
- all_done_o  out  1  registered: &core_done_o and all buffers empty.

Behaviour:
- Reset: all buffers empty; round-robin pointer = 0; lock cleared. All outputs 0 in the cycle after reset_i is sampled high. A reset mid-transfer discards all buffered records without delivering them.
- Enqueue: each core has a FIFO of fifo_els_p entries holding {data, finish, pass, stamp}. rec_v_i[i] writes in the same cycle it is sampled; the entry is visible at the output the next cycle earliest (1-cycle minimum latency).
- Full handling: if the core i FIFO is full and core i is not dequeued that cycle, the record is dropped and overflow_o[i] is set. If core i is dequeued in the same cycle, the write succeeds (simultaneous push/pop on full). Pointers wrap modulo fifo_els_p.
- FSM, two states:
  - IDLE: trace_v_o = |(~empty). Grant = first non-empty core at or after rr_ptr, searching upward with wrap. If trace_v_o & trace_ready_i: pop that core, set rr_ptr = grant+1 (mod num_core_p), stay in IDLE. If trace_v_o & ~trace_ready_i: latch the grant and go to HOLD.
  - HOLD: grant is frozen. trace_v_o = 1 and all trace_* outputs stay stable regardless of new arrivals. On trace_ready_i: pop, advance rr_ptr past the grant, return to IDLE.
- Output data/core/finish/stamp are driven from the granted FIFO head (combinational read). Valid/ready rules: valid never drops without a handshake; outputs are don't-care when trace_v_o = 0.
- Finish: when a record with finish = 1 from core i is handed off, set core_done_o[i] and core_pass_o[i] = pass. A later finish from the same core overwrites core_pass_o[i] (last wins). Records arriving after done are still accepted and delivered.
- all_done_o: registered; rises one cycle after both conditions hold (&core_done_o and all buffers empty). Sticky until reset.
- Sticky flags clear only on reset.

Optional Feature:
- Macro: BP_BE_TRACE_ARB_TIMESTAMP_EN.
- Defined: a free-running 32-bit cycle counter (0 at reset, wraps at 2^32) is captured into the FIFO entry at enqueue and presented on trace_stamp_o.
- Undefined: no counter and no stamp storage in the FIFOs; trace_stamp_o is tied to 0.

Test Plan:
- Single core 0: push records A, B with trace_ready_i = 1 -> A out on cycle +1, B on cycle +2, trace_core_o = 0 both times.
- Cores 0..3 all push in the same cycle, ready held 1 -> delivery order 0, 1, 2, 3. Then cores 0 and 2 push -> order 0, 2 (rr_ptr was 0 after delivering core 3, then advances past each grant).
- Core 1 valid, ready held 0 for 5 cycles while core 0 pushes -> trace_core_o = 1 with data stable all 5 cycles (HOLD), then core 0 delivered after the handshake.
- fifo_els_p = 4, ready = 0, core 2 pushes 5 records -> overflow_o[2] = 1 on 5th. Then ready = 1 -> exactly 4 records delivered. Repeat at full with ready = 1 during the push -> no overflow.
- Cores 0..3 push finish records with pass = 1, 1, 0, 1 -> core_done_o = 4'hF, core_pass_o = 4'hB, all_done_o rises one cycle after the last handshake. Reset mid-stream -> all outputs 0 the next cycle.
- With BP_BE_TRACE_ARB_TIMESTAMP_EN, push at cycles 3 and 10 after reset -> trace_stamp_o = 3, 10. Without the macro -> trace_stamp_o = 0.

Source files
------------

// File: rtl/bp_be_trace_arbiter.sv
// bp_be_trace_arbiter
//   Collects per-core commit trace records, buffers each core in a small FIFO
//   and serializes them round-robin onto one trace/host channel. It also
//   tracks per-core test completion from finish records and raises
//   all_done_o once every core has finished and every buffer has drained.
//
// Optional build macro: BP_BE_TRACE_ARB_TIMESTAMP_EN
//   Defined   : a free-running 32-bit cycle counter is captured per record at
//               enqueue and presented on trace_stamp_o.
//   Undefined : no counter or stamp storage; trace_stamp_o is tied to 0.
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   rec_v_i[n]                per-core record valid (no backpressure)
//   rec_data_i[n*w]           per-core records, core i at [i*w +: w]
//   rec_finish_i[n]           record is a test-finish record
//   rec_pass_i[n]             finish outcome (1 = pass)
//   trace_v_o / trace_ready_i output channel handshake
//   trace_data_o              granted record
//   trace_core_o              source core of the granted record
//   trace_finish_o            granted record is a finish record
//   trace_stamp_o             enqueue timestamp (0 when feature disabled)
//   core_done_o[n]            sticky: core finish record delivered
//   core_pass_o[n]            sticky pass flag (valid where core_done_o set)
//   overflow_o[n]             sticky: a record from that core was dropped
//   all_done_o                all cores done and all buffers empty
module bp_be_trace_arbiter #(
  parameter  int unsigned num_core_p       = 4,
  parameter  int unsigned rec_width_p      = 128,
  parameter  int unsigned fifo_els_p       = 4,
  localparam int unsigned core_id_width_lp = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_core_p-1:0]             rec_v_i,
  input  logic [num_core_p*rec_width_p-1:0] rec_data_i,
  input  logic [num_core_p-1:0]             rec_finish_i,
  input  logic [num_core_p-1:0]             rec_pass_i,
  output logic                              trace_v_o,
  input  logic                              trace_ready_i,
  output logic [rec_width_p-1:0]            trace_data_o,
  output logic [core_id_width_lp-1:0]       trace_core_o,
  output logic                              trace_finish_o,
  output logic [31:0]                       trace_stamp_o,
  output logic [num_core_p-1:0]             core_done_o,
  output logic [num_core_p-1:0]             core_pass_o,
  output logic [num_core_p-1:0]             overflow_o,
  output logic                              all_done_o
);

  localparam int unsigned ptr_w_lp      = $clog2(fifo_els_p);
  localparam int unsigned ptr_full_w_lp = ptr_w_lp + 1;

  typedef enum logic {ST_IDLE = 1'b0, ST_HOLD = 1'b1} state_e;

  // FIFO storage and pointers (extra MSB distinguishes full from empty)
  logic [rec_width_p-1:0]   r_mem_data   [num_core_p][fifo_els_p];
  logic [fifo_els_p-1:0]    r_mem_finish [num_core_p];
  logic [fifo_els_p-1:0]    r_mem_pass   [num_core_p];
  logic [ptr_full_w_lp-1:0] r_wptr       [num_core_p];
  logic [ptr_full_w_lp-1:0] r_rptr       [num_core_p];

  state_e                      r_state;
  logic [core_id_width_lp-1:0] r_rr;
  logic [core_id_width_lp-1:0] r_grant;
  logic [num_core_p-1:0]       r_done;
  logic [num_core_p-1:0]       r_pass;
  logic [num_core_p-1:0]       r_ovf;
  logic                        r_all_done;

  logic [num_core_p-1:0]       w_empty;
  logic [num_core_p-1:0]       w_full;
  logic [num_core_p-1:0]       w_push;
  logic [num_core_p-1:0]       w_pop;
  logic [num_core_p-1:0]       w_drop;
  logic                        w_found;
  logic [core_id_width_lp-1:0] w_sel;
  logic [core_id_width_lp-1:0] w_grant;
  logic [core_id_width_lp-1:0] w_next_rr;
  logic                        w_valid;
  logic                        w_handoff;
  logic [ptr_w_lp-1:0]         w_head_idx;
  logic [rec_width_p-1:0]      w_head_data;
  logic                        w_head_finish;
  logic                        w_head_pass;
  logic [31:0]                 w_head_stamp;

`ifdef BP_BE_TRACE_ARB_TIMESTAMP_EN
  logic [31:0] r_cycle;
  logic [31:0] r_mem_stamp [num_core_p][fifo_els_p];

  // Free-running enqueue timestamp
  always_ff @(posedge clk_i) begin
    if (reset_i) r_cycle <= '0;
    else         r_cycle <= r_cycle + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_core_p; i++) begin
      if (w_push[i]) r_mem_stamp[i][r_wptr[i][ptr_w_lp-1:0]] <= r_cycle;
    end
  end

  assign w_head_stamp = r_mem_stamp[w_grant][w_head_idx];
`else
  assign w_head_stamp = 32'd0;
`endif

  // FIFO status and round-robin search starting at r_rr
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int unsigned i = 0; i < num_core_p; i++) begin
      w_empty[i] = (r_wptr[i] == r_rptr[i]);
      w_full[i]  = (r_wptr[i][ptr_w_lp] != r_rptr[i][ptr_w_lp]) &&
                   (r_wptr[i][ptr_w_lp-1:0] == r_rptr[i][ptr_w_lp-1:0]);
    end
    for (int unsigned k = 0; k < num_core_p; k++) begin
      int unsigned idx;
      idx = (32'(r_rr) + k) % num_core_p;
      if (!w_found && !w_empty[idx]) begin
        w_found = 1'b1;
        w_sel   = core_id_width_lp'(idx);
      end
    end
  end

  // HOLD freezes the grant; only a handshake can move the head of that FIFO
  assign w_grant   = (r_state == ST_HOLD) ? r_grant : w_sel;
  assign w_valid   = (r_state == ST_HOLD) | w_found;
  assign w_handoff = w_valid & trace_ready_i;
  assign w_next_rr = (w_grant == core_id_width_lp'(num_core_p - 1)) ? '0
                   : w_grant + core_id_width_lp'(1);

  // A full FIFO still accepts a write when it is popped in the same cycle
  always_comb begin
    for (int unsigned i = 0; i < num_core_p; i++) begin
      w_pop[i]  = w_handoff && (w_grant == core_id_width_lp'(i));
      w_push[i] = rec_v_i[i] && (!w_full[i] || w_pop[i]);
      w_drop[i] = rec_v_i[i] && w_full[i] && !w_pop[i];
    end
  end

  assign w_head_idx    = r_rptr[w_grant][ptr_w_lp-1:0];
  assign w_head_data   = r_mem_data[w_grant][w_head_idx];
  assign w_head_finish = r_mem_finish[w_grant][w_head_idx];
  assign w_head_pass   = r_mem_pass[w_grant][w_head_idx];

  // Record storage (no reset needed; guarded by pointers)
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_core_p; i++) begin
      if (w_push[i]) begin
        r_mem_data[i][r_wptr[i][ptr_w_lp-1:0]]   <= rec_data_i[i*rec_width_p +: rec_width_p];
        r_mem_finish[i][r_wptr[i][ptr_w_lp-1:0]] <= rec_finish_i[i];
        r_mem_pass[i][r_wptr[i][ptr_w_lp-1:0]]   <= rec_pass_i[i];
      end
    end
  end

  // FIFO pointers
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_core_p; i++) begin
      if (reset_i) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end else begin
        if (w_push[i]) r_wptr[i] <= r_wptr[i] + ptr_full_w_lp'(1);
        if (w_pop[i])  r_rptr[i] <= r_rptr[i] + ptr_full_w_lp'(1);
      end
    end
  end

  // Arbitration FSM
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= ST_IDLE;
      r_rr    <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid && trace_ready_i) begin
            r_rr <= w_next_rr;
          end else if (w_valid) begin
            r_grant <= w_sel;
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (trace_ready_i) begin
            r_rr    <= w_next_rr;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Sticky completion/overflow flags; all_done sees last cycle's state
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_done     <= '0;
      r_pass     <= '0;
      r_ovf      <= '0;
      r_all_done <= 1'b0;
    end else begin
      r_ovf      <= r_ovf | w_drop;
      r_all_done <= r_all_done | ((&r_done) & (&w_empty));
      if (w_handoff && w_head_finish) begin
        r_done[w_grant] <= 1'b1;
        r_pass[w_grant] <= w_head_pass;
      end
    end
  end

  // Trace outputs forced to 0 when idle so nothing stale leaks out
  assign trace_v_o      = w_valid;
  assign trace_data_o   = w_valid ? w_head_data   : '0;
  assign trace_core_o   = w_valid ? w_grant       : '0;
  assign trace_finish_o = w_valid & w_head_finish;
  assign trace_stamp_o  = w_valid ? w_head_stamp  : 32'd0;
  assign core_done_o    = r_done;
  assign core_pass_o    = r_pass;
  assign overflow_o     = r_ovf;
  assign all_done_o     = r_all_done;

endmodule

// File: tb/tb_bp_be_trace_arbiter.sv
// Randomized + directed bench for bp_be_trace_arbiter against a queue-based
// reference model of the arbitration, buffering and completion rules.
module tb_bp_be_trace_arbiter;

  localparam int unsigned NC  = 4;
  localparam int unsigned RW  = 128;
  localparam int unsigned ELS = 4;

  logic             clk;
  logic             reset_i;
  logic [NC-1:0]    rec_v_i;
  logic [NC*RW-1:0] rec_data_i;
  logic [NC-1:0]    rec_finish_i;
  logic [NC-1:0]    rec_pass_i;
  logic             trace_v_o;
  logic             trace_ready_i;
  logic [RW-1:0]    trace_data_o;
  logic [1:0]       trace_core_o;
  logic             trace_finish_o;
  logic [31:0]      trace_stamp_o;
  logic [NC-1:0]    core_done_o;
  logic [NC-1:0]    core_pass_o;
  logic [NC-1:0]    overflow_o;
  logic             all_done_o;

  bp_be_trace_arbiter #(.num_core_p(NC), .rec_width_p(RW), .fifo_els_p(ELS)) dut (
    .clk_i(clk), .reset_i(reset_i), .rec_v_i(rec_v_i), .rec_data_i(rec_data_i),
    .rec_finish_i(rec_finish_i), .rec_pass_i(rec_pass_i), .trace_v_o(trace_v_o),
    .trace_ready_i(trace_ready_i), .trace_data_o(trace_data_o),
    .trace_core_o(trace_core_o), .trace_finish_o(trace_finish_o),
    .trace_stamp_o(trace_stamp_o), .core_done_o(core_done_o),
    .core_pass_o(core_pass_o), .overflow_o(overflow_o), .all_done_o(all_done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [RW-1:0] data;
    logic          fin;
    logic          pas;
    logic [31:0]   stamp;
  } rec_t;

  // reference model state
  rec_t          m_q [NC][$];
  int            m_rr;
  bit            m_hold;
  int            m_hold_core;
  logic [NC-1:0] m_done, m_pass, m_ovf;
  logic          m_ad;
  logic [31:0]   m_cycle;

  // observed handshakes for directed order/stamp checks
  int          obs_core [$];
  logic [31:0] obs_stamp [$];

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int model_grant();
    if (m_hold) return m_hold_core;
    for (int k = 0; k < NC; k++) begin
      int c;
      c = (m_rr + k) % NC;
      if (m_q[c].size() != 0) return c;
    end
    return -1;
  endfunction

  function automatic bit model_all_empty();
    for (int c = 0; c < NC; c++) if (m_q[c].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NC; c++) m_q[c].delete();
    m_rr = 0; m_hold = 0; m_hold_core = 0;
    m_done = '0; m_pass = '0; m_ovf = '0; m_ad = 1'b0; m_cycle = 32'd0;
  endtask

  // One cycle: drive inputs, check outputs vs model, advance model and clock
  task automatic step(input logic [NC-1:0] v, input logic [NC-1:0] fin,
                      input logic [NC-1:0] pas, input logic rdy);
    rec_t    d [NC];
    int      g;
    logic    nxt_ad;
    rec_t    h;
    for (int c = 0; c < NC; c++) begin
      d[c].data  = {$urandom, $urandom, $urandom, $urandom};
      d[c].fin   = fin[c];
      d[c].pas   = pas[c];
      d[c].stamp = m_cycle;
      rec_data_i[c*RW +: RW] = d[c].data;
    end
    rec_v_i = v; rec_finish_i = fin; rec_pass_i = pas; trace_ready_i = rdy;
    #1;
    g = model_grant();
    chk("valid", trace_v_o, (g >= 0));
    if (g >= 0) begin
      chk("core",   trace_core_o,   g);
      chk("data",   trace_data_o,   m_q[g][0].data);
      chk("finish", trace_finish_o, m_q[g][0].fin);
`ifdef BP_BE_TRACE_ARB_TIMESTAMP_EN
      chk("stamp",  trace_stamp_o,  m_q[g][0].stamp);
`else
      chk("stamp",  trace_stamp_o,  32'd0);
`endif
    end
    chk("done",     core_done_o,               m_done);
    chk("pass",     core_pass_o & core_done_o, m_pass & m_done);
    chk("overflow", overflow_o,                m_ovf);
    chk("all_done", all_done_o,                m_ad);
    if (trace_v_o && rdy) begin
      obs_core.push_back(int'(trace_core_o));
      obs_stamp.push_back(trace_stamp_o);
    end
    // model update at the coming edge
    nxt_ad = m_ad | ((&m_done) & model_all_empty());
    if (g >= 0 && rdy) begin
      h = m_q[g].pop_front();
      if (h.fin) begin m_done[g] = 1'b1; m_pass[g] = h.pas; end
      m_rr = (g + 1) % NC;
      m_hold = 0;
    end else if (g >= 0) begin
      m_hold = 1; m_hold_core = g;
    end
    for (int c = 0; c < NC; c++) begin
      if (v[c]) begin
        if (m_q[c].size() < ELS) m_q[c].push_back(d[c]);
        else m_ovf[c] = 1'b1;
      end
    end
    m_ad = nxt_ad;
    m_cycle = m_cycle + 32'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    rec_v_i = '0; rec_finish_i = '0; rec_pass_i = '0; trace_ready_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset_i = 1'b0;
    model_clear();
    obs_core.delete();
    obs_stamp.delete();
    #1;
    chk("rst_v",      trace_v_o,      1'b0);
    chk("rst_data",   trace_data_o,   '0);
    chk("rst_core",   trace_core_o,   '0);
    chk("rst_finish", trace_finish_o, 1'b0);
    chk("rst_stamp",  trace_stamp_o,  '0);
    chk("rst_done",   core_done_o,    '0);
    chk("rst_pass",   core_pass_o,    '0);
    chk("rst_ovf",    overflow_o,     '0);
    chk("rst_alldone", all_done_o,    1'b0);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step('0, '0, '0, rdy);
  endtask

  initial begin
    reset_i = 1'b1; rec_v_i = '0; rec_data_i = '0; rec_finish_i = '0;
    rec_pass_i = '0; trace_ready_i = 1'b0;
    @(negedge clk);
    do_reset();

    // single core, back-to-back records
    step(4'b0001, '0, '0, 1'b1);
    step(4'b0001, '0, '0, 1'b1);
    idle(3, 1'b1);
    chk("single_cnt", obs_core.size(), 2);

    // all cores at once, then cores 0 and 2
    do_reset();
    step(4'b1111, '0, '0, 1'b1);
    idle(5, 1'b1);
    step(4'b0101, '0, '0, 1'b1);
    idle(3, 1'b1);
    chk("rr_cnt", obs_core.size(), 6);
    if (obs_core.size() == 6) begin
      chk("rr_o0", obs_core[0], 0); chk("rr_o1", obs_core[1], 1);
      chk("rr_o2", obs_core[2], 2); chk("rr_o3", obs_core[3], 3);
      chk("rr_o4", obs_core[4], 0); chk("rr_o5", obs_core[5], 2);
    end

    // HOLD: core 1 stalled while core 0 arrives
    obs_core.delete();
    step(4'b0010, '0, '0, 1'b0);
    step(4'b0001, '0, '0, 1'b0);
    idle(4, 1'b0);
    idle(3, 1'b1);
    chk("hold_cnt", obs_core.size(), 2);
    if (obs_core.size() == 2) begin
      chk("hold_o0", obs_core[0], 1); chk("hold_o1", obs_core[1], 0);
    end

    // overflow on 5th push into a full FIFO
    do_reset();
    for (int i = 0; i < 5; i++) step(4'b0100, '0, '0, 1'b0);
    chk("ovf_set", overflow_o, 4'b0100);
    idle(6, 1'b1);
    chk("ovf_drain", obs_core.size(), 4);
    // push into full FIFO while it is being popped
    do_reset();
    for (int i = 0; i < 4; i++) step(4'b0100, '0, '0, 1'b0);
    step(4'b0100, '0, '0, 1'b1);
    idle(6, 1'b1);
    chk("ovf_none", overflow_o, 4'b0000);
    chk("full_pp_cnt", obs_core.size(), 5);

    // finish records and completion
    do_reset();
    step(4'b1111, 4'b1111, 4'b1011, 1'b1);
    idle(6, 1'b1);
    chk("fin_done", core_done_o, 4'hF);
    chk("fin_pass", core_pass_o, 4'hB);
    chk("fin_alldone", all_done_o, 1'b1);
    // mid-stream reset discards buffered records
    step(4'b1111, '0, '0, 1'b0);
    step(4'b0011, '0, '0, 1'b0);
    do_reset();
    idle(2, 1'b1);

    // timestamps at cycles 3 and 10 after reset
    do_reset();
    idle(3, 1'b1);
    step(4'b0001, '0, '0, 1'b1);
    idle(6, 1'b1);
    step(4'b0001, '0, '0, 1'b1);
    idle(2, 1'b1);
    chk("ts_cnt", obs_stamp.size(), 2);
    if (obs_stamp.size() == 2) begin
`ifdef BP_BE_TRACE_ARB_TIMESTAMP_EN
      chk("ts_a", obs_stamp[0], 32'd3);
      chk("ts_b", obs_stamp[1], 32'd10);
`else
      chk("ts_a", obs_stamp[0], 32'd0);
      chk("ts_b", obs_stamp[1], 32'd0);
`endif
    end

    // randomized traffic with an occasional mid-run reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic [NC-1:0] v, f, p;
      logic r;
      v = 4'($urandom) & 4'($urandom);
      f = '0;
      for (int c = 0; c < NC; c++) f[c] = ($urandom_range(0, 7) == 0);
      p = 4'($urandom);
      r = (i % 200 < 30) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
      if (i == 1500) do_reset();
      step(v, f, p, r);
    end
    idle(20, 1'b1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
